// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, control FSM states and special-case result constants.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q   = 32'h8000_0000;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Two's complement negate; wraps so that INT_MIN maps to itself.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate step and the
// divide trial subtract.
module muldiv_addsub (
  input  logic [32:0] op_a,
  input  logic [32:0] op_b,
  input  logic        sub,
  output logic [32:0] y
);

  always_comb begin
    y = op_a + (op_b ^ {33{sub}}) + {32'd0, sub};
  end

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiplier and restoring
// divider behind a start/busy/done handshake, with a sign fix-up state.
module rv32m_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output muldiv_state_e    dbg_state
);

  // Handshake: a request is taken when start=1 and busy=0; r is valid while
  // done=1 and is held until the next accepted request.

  muldiv_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opb_q, opb_d;
  logic [31:0]   r_q, r_d;

  logic          accept;
  logic          a_signed, b_signed, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag;
  logic          div0, ovf, special;
  logic [31:0]   special_r;

  logic [32:0]   as_a, as_b, as_y;
  logic          as_sub;
  logic [32:0]   shifted;
  logic [63:0]   step_acc;

  logic [63:0]   prod_s;
  logic [31:0]   quo_s, rem_s, fix_res;

  assign accept = (state_q == IDLE) && start;

  // Acceptance decode: operand signedness, magnitudes and bypass cases.
  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && a[31];
    b_neg    = b_signed && b[31];
    a_mag    = a_neg ? neg32(a) : a;
    b_mag    = b_neg ? neg32(b) : b;
    div0     = funct3[2] && (b == 32'd0);
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    special  = div0 || ovf;
    if (div0) begin
      special_r = funct3[1] ? a : DIV0_Q;
    end else begin
      special_r = funct3[1] ? 32'd0 : OVF_Q;
    end
  end

  // Divide shifts the next dividend bit into the partial remainder before the
  // trial subtract; multiply adds the multiplicand when the low bit is set.
  always_comb begin
    shifted = {acc_q[63:32], acc_q[31]};
    as_sub  = op_q[2];
    if (op_q[2]) begin
      as_a = shifted;
      as_b = {1'b0, opb_q};
    end else begin
      as_a = {1'b0, acc_q[63:32]};
      as_b = acc_q[0] ? {1'b0, opb_q} : 33'd0;
    end
  end

  muldiv_addsub u_addsub (
    .op_a (as_a),
    .op_b (as_b),
    .sub  (as_sub),
    .y    (as_y)
  );

  always_comb begin
    if (op_q[2]) begin
      if (!as_y[32]) begin
        step_acc = {as_y[31:0], acc_q[30:0], 1'b1};
      end else begin
        step_acc = {shifted[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      step_acc = {as_y, acc_q[31:1]};
    end
  end

  // Sign fix-up on the unsigned result held in the accumulator.
  always_comb begin
    prod_s  = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    quo_s   = (sa_q ^ sb_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
    rem_s   = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];
    if (!op_q[2]) begin
      fix_res = (op_q == F3_MUL) ? prod_s[31:0] : prod_s[63:32];
    end else begin
      fix_res = op_q[1] ? rem_s : quo_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == 5'd31) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    r         = r_q;
    dbg_state = state_q;
  end

  // Datapath next values.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    acc_d = acc_q;
    opb_d = opb_q;
    r_d   = r_q;
    if (accept) begin
      cnt_d = 5'd0;
      op_d  = funct3;
      sa_d  = a_neg;
      sb_d  = b_neg;
      if (funct3[2]) begin
        acc_d = {32'd0, a_mag};
        opb_d = b_mag;
      end else begin
        acc_d = {32'd0, b_mag};
        opb_d = a_mag;
      end
      if (special) r_d = special_r;
    end else if (state_q == CALC) begin
      acc_d = step_acc;
      cnt_d = cnt_q + 5'd1;
    end else if (state_q == FIX) begin
      r_d = fix_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 5'd0;
      op_q  <= 3'd0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      acc_q <= 64'd0;
      opb_q <= 32'd0;
      r_q   <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed bench for rv32m_muldiv: hand-computed results, latency, busy
// profile, ignored starts and asynchronous reset mid-operation.
module tb_rv32m_muldiv;
  import muldiv_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    funct3;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          busy;
  logic          done;
  logic [31:0]   r;
  muldiv_state_e dbg_state;

  int            n_checks;
  int            n_fail;
  logic [31:0]   exp_q[$];

  rv32m_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .r         (r),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request and watch cycles 1..lat+3 after acceptance; p1/p2 are
  // cycles in which a spurious start with random operands is driven.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] expr, input int lat,
                        input int p1, input int p2);
    int ndone;
    int dcyc;
    int busy_bad;
    ndone    = 0;
    dcyc     = 0;
    busy_bad = 0;
    @(negedge clk);
    funct3 = f3;
    a      = av;
    b      = bv;
    start  = 1'b1;
    exp_q.push_back(expr);
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    for (int i = 1; i <= lat + 3; i++) begin
      @(negedge clk);
      if (busy !== (i <= lat)) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        dcyc = i;
        if (exp_q.size() > 0) check({tag, ".r"}, r, exp_q.pop_front());
      end
      if (i == p1 || i == p2) begin
        start  = 1'b1;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, 32'(dcyc), 32'(lat));
    check({tag, ".ndone"}, 32'(ndone), 32'd1);
    check({tag, ".busy"}, 32'(busy_bad), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int ndone;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    #2;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.r", r, 32'd0);
    check("rst.state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Multiply, with ignored starts in cycle 5 and in the DONE cycle.
    run_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5, 34);
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 0);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0, 0);
    run_op("mulh_m1",F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0, 0);

    // Divide and remainder.
    run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0, 0);
    run_op("divu",   F3_DIVU,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34, 0, 0);
    run_op("remu",   F3_REMU,   32'd100,       32'd7,         32'd2,         34, 0, 0);
    run_op("div_min",F3_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 34, 0, 0);

    // Special cases bypass the iterations.
    run_op("divu0",  F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, 0);
    run_op("rem0",   F3_REM,    32'd5,         32'd0,         32'd5,         1, 0, 0);
    run_op("div0",   F3_DIV,    32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1, 0, 0);
    run_op("divovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op("removf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0);

    // Leave a nonzero r, then reset mid-operation in cycle 10.
    run_op("mul2",   F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0);
    @(negedge clk);
    funct3 = F3_DIVU;
    a      = 32'hFFFF_FFFF;
    b      = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.r", r, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("arst.nodone", 32'(ndone), 32'd0);
    run_op("post_rst", F3_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
